// File: rtl/fpmult_pkg.sv
`default_nettype none
// ============================================================================
// Package    : fpmult_pkg
// Description: Shared constants and stage payload types for the FP multiplier
//              round/pack stage. Field offsets describe the IEEE-754 single
//              precision word {sign, exponent[7:0], fraction[22:0]}.
// Revision   : 1.0  initial release
// ============================================================================
package fpmult_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Biased exponent with every field bit set (inf/NaN encoding).
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Packed-result field offsets
  localparam int P_SIGN    = 31;
  localparam int P_EXP_MSB = 30;
  localparam int P_EXP_LSB = 23;
  localparam int P_MAN_MSB = 22;

  // Stage 1 payload: rounded significand (hidden bit + carry) and context
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [MAN_W+1:0] sum;
    logic             nan;
    logic             inf;
    logic             zero;
    logic             inexact;
  } s1_t;

  // Stage 2 payload: packed word and status flags
  typedef struct packed {
    logic [31:0] p;
    logic        ovf;
    logic        unf;
    logic        inexact;
  } s2_t;

endpackage : fpmult_pkg
`default_nettype wire

// File: rtl/fpmult_round_pack_if.sv
`default_nettype none
// ============================================================================
// Interface  : fpmult_round_pack_if
// Description: Upstream (normalize stage) and downstream handshake bundle of
//              the round/pack stage.
//   master : driven by the producer/consumer environment
//   slave  : the round/pack stage itself
//   in_*   : valid/ready beat carrying sign, fraction, 9-bit exponent, GRS
//            bits and special-case flags
//   out_*  : valid/ready beat carrying packed word and ovf/unf/inexact flags
// Revision   : 1.0  initial release
// ============================================================================
interface fpmult_round_pack_if;
  import fpmult_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [MAN_W-1:0] in_man;
  logic [EXP_W:0]   in_exp;
  logic             in_g;
  logic             in_r;
  logic             in_s;
  logic             in_nan;
  logic             in_inf;
  logic             in_zero;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_p;
  logic             out_ovf;
  logic             out_unf;
  logic             out_inexact;

  modport master (
    output in_valid, in_sign, in_man, in_exp, in_g, in_r, in_s,
           in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, out_p, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_man, in_exp, in_g, in_r, in_s,
           in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_p, out_ovf, out_unf, out_inexact
  );

endinterface : fpmult_round_pack_if
`default_nettype wire

// File: rtl/fpmult_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module     : fpmult_pipe_reg
// Description: Enable-gated valid + payload pipeline register. Loads both
//              valid and data when en is high, otherwise holds them.
//   clk, rst : clock, asynchronous active-high reset (clears valid and data)
//   en       : load enable (stage advance)
//   valid_d  : next valid      data_d : next payload
//   valid_q  : held valid      data_q : held payload
// Revision   : 1.0  initial release
// ============================================================================
module fpmult_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule : fpmult_pipe_reg
`default_nettype wire

// File: rtl/fpmult_round_pack.sv
`default_nettype none
// ============================================================================
// Module     : fpmult_round_pack
// Description: Final FP multiplier stage. Stage 1 applies round-to-nearest-
//              even (or truncation) to the normalized fraction; stage 2
//              renormalizes on rounding carry, resolves NaN/inf/zero and
//              overflow/underflow, and packs an IEEE-754 single word.
//              Two-stage elastic pipeline, 1 result/cycle, 2-cycle latency.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fpmult_round_pack_if (in_* beat, out_* beat)
// Revision   : 1.0  initial release
// ============================================================================
module fpmult_round_pack
  import fpmult_pkg::*;
#(
  parameter int EXP_W    = fpmult_pkg::EXP_W,
  parameter int MAN_W    = fpmult_pkg::MAN_W,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  fpmult_round_pack_if.slave        bus
);

  logic adv1;
  logic adv2;
  logic v1_q;
  logic v2_q;
  s1_t  s1_d;
  s1_t  s1_q;
  s2_t  s2_d;
  s2_t  s2_q;

  // A stage may load when its successor can take its contents or it is empty.
  assign adv2         = bus.out_ready | ~v2_q;
  assign adv1         = adv2 | ~v1_q;
  assign bus.in_ready = adv1;

  // --------------------------------------------------------------------------
  // Stage 1: rounding increment
  // --------------------------------------------------------------------------
  logic inc;

  always_comb begin
    // Round up when above the halfway point, or exactly halfway with odd LSB.
    inc = ROUND_EN & bus.in_g & (bus.in_r | bus.in_s | bus.in_man[0]);

    s1_d         = '0;
    s1_d.sign    = bus.in_sign;
    s1_d.exp     = bus.in_exp;
    s1_d.sum     = {2'b01, bus.in_man} + (MAN_W + 2)'(inc);
    s1_d.nan     = bus.in_nan;
    s1_d.inf     = bus.in_inf;
    s1_d.zero    = bus.in_zero;
    s1_d.inexact = bus.in_g | bus.in_r | bus.in_s;
  end

  fpmult_pipe_reg #(
    .W ($bits(s1_t))
  ) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .en      (adv1),
    .valid_d (bus.in_valid),
    .data_d  (s1_d),
    .valid_q (v1_q),
    .data_q  (s1_q)
  );

  // --------------------------------------------------------------------------
  // Stage 2: renormalize, classify, pack
  // --------------------------------------------------------------------------
  logic [EXP_W+1:0] exp_adj;
  logic [MAN_W-1:0] frac;

  always_comb begin
    // One extra exponent bit so a carry on a 9-bit exponent cannot wrap.
    exp_adj = {1'b0, s1_q.exp} + (EXP_W + 2)'(s1_q.sum[MAN_W+1]);
    // Carry-out means the significand became exactly 2.0: shift right once.
    frac    = s1_q.sum[MAN_W+1] ? s1_q.sum[MAN_W:1] : s1_q.sum[MAN_W-1:0];

    s2_d = '0;
    if (s1_q.nan) begin
      s2_d.p = QNAN;
    end else if (s1_q.inf) begin
      s2_d.p[P_SIGN]              = s1_q.sign;
      s2_d.p[P_EXP_MSB:P_EXP_LSB] = '1;
    end else if (s1_q.zero) begin
      s2_d.p[P_SIGN] = s1_q.sign;
    end else if (exp_adj >= (EXP_W + 2)'(EXP_MAX)) begin
      s2_d.p[P_SIGN]              = s1_q.sign;
      s2_d.p[P_EXP_MSB:P_EXP_LSB] = '1;
      s2_d.ovf                    = 1'b1;
      s2_d.inexact                = 1'b1;
    end else if (exp_adj == '0) begin
      // No subnormal support: flush to signed zero.
      s2_d.p[P_SIGN] = s1_q.sign;
      s2_d.unf       = 1'b1;
      s2_d.inexact   = 1'b1;
    end else begin
      s2_d.p[P_SIGN]              = s1_q.sign;
      s2_d.p[P_EXP_MSB:P_EXP_LSB] = exp_adj[EXP_W-1:0];
      s2_d.p[P_MAN_MSB:0]         = frac;
      s2_d.inexact                = s1_q.inexact;
    end
  end

  fpmult_pipe_reg #(
    .W ($bits(s2_t))
  ) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .en      (adv2),
    .valid_d (v1_q),
    .data_d  (s2_d),
    .valid_q (v2_q),
    .data_q  (s2_q)
  );

  assign bus.out_valid   = v2_q;
  assign bus.out_p       = s2_q.p;
  assign bus.out_ovf     = s2_q.ovf;
  assign bus.out_unf     = s2_q.unf;
  assign bus.out_inexact = s2_q.inexact;

endmodule : fpmult_round_pack
`default_nettype wire

// File: tb/tb_fpmult_round_pack.sv
`default_nettype none
// ============================================================================
// Module     : tb_fpmult_round_pack
// Description: Testbench for fpmult_round_pack. Directed vectors, randomized
//              streaming with random back-pressure, stall and mid-flight
//              reset scenarios, all checked against a value-level model.
// Revision   : 1.0  initial release
// ============================================================================
module tb_fpmult_round_pack;

  typedef struct packed {
    logic        sign;
    logic [22:0] man;
    logic [8:0]  exp;
    logic        g, r, s, nan, inf, zero;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fpmult_round_pack_if bus ();

  fpmult_round_pack #(
    .EXP_W    (8),
    .MAN_W    (23),
    .ROUND_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: {packed word, ovf, unf, inexact} from the value-level rules.
  function automatic logic [34:0] model(input beat_t b);
    logic [31:0] sig;
    logic [31:0] e;
    logic        inx;
    inx = b.g | b.r | b.s;
    sig = 32'h0080_0000 + {9'd0, b.man};
    if (b.g && (b.r || b.s || b.man[0])) sig = sig + 1;
    e = {23'd0, b.exp};
    if (sig >= 32'h0100_0000) begin
      sig = sig / 2;
      e   = e + 1;
    end
    if (b.nan)  return {32'h7FC0_0000, 3'b000};
    if (b.inf)  return {b.sign, 8'hFF, 23'd0, 3'b000};
    if (b.zero) return {b.sign, 31'd0, 3'b000};
    if (e >= 255) return {b.sign, 8'hFF, 23'd0, 3'b101};
    if (e == 0)   return {b.sign, 31'd0, 3'b011};
    return {b.sign, e[7:0], sig[22:0], 2'b00, inx};
  endfunction

  function automatic beat_t mk(input logic sign, input logic [22:0] man,
                               input logic [8:0] exp, input logic g, r, s,
                               input logic nan, inf, zero);
    beat_t b;
    b.sign = sign; b.man = man; b.exp = exp;
    b.g = g; b.r = r; b.s = s; b.nan = nan; b.inf = inf; b.zero = zero;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int    sel;
    b.sign = 1'($urandom);
    sel    = $urandom_range(0, 3);
    b.man  = (sel == 0) ? 23'h7FFFFF : 23'($urandom);
    sel    = $urandom_range(0, 9);
    case (sel)
      0:       b.exp = 9'd0;
      1:       b.exp = 9'd1;
      2:       b.exp = 9'd254;
      3:       b.exp = 9'd255;
      4:       b.exp = 9'($urandom_range(256, 511));
      default: b.exp = 9'($urandom_range(1, 253));
    endcase
    b.g    = 1'($urandom);
    b.r    = 1'($urandom);
    b.s    = 1'($urandom);
    b.nan  = ($urandom_range(0, 15) == 0);
    b.inf  = ($urandom_range(0, 15) == 0);
    b.zero = ($urandom_range(0, 15) == 0);
    return b;
  endfunction

  task automatic drive(input beat_t b, input logic v);
    bus.in_valid = v;
    bus.in_sign  = b.sign;
    bus.in_man   = b.man;
    bus.in_exp   = b.exp;
    bus.in_g     = b.g;
    bus.in_r     = b.r;
    bus.in_s     = b.s;
    bus.in_nan   = b.nan;
    bus.in_inf   = b.inf;
    bus.in_zero  = b.zero;
  endtask

  function automatic logic [34:0] obs();
    return {bus.out_p, bus.out_ovf, bus.out_unf, bus.out_inexact};
  endfunction

  // One beat through an idle pipeline with out_ready held high.
  task automatic run_one(input beat_t b, output logic v_early,
                         output logic v_on, output logic [34:0] o);
    @(negedge clk);
    drive(b, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 v_early = bus.out_valid;
    @(negedge clk);
    #1 v_on = bus.out_valid;
    o = obs();
  endtask

  task automatic drain();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    drive('0, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    n_vec++;
    if (obs() !== 35'd0) begin
      n_bad++; $display("FAIL reset_out_p_flags: got %h, expected 0", obs());
    end
  endtask

  task automatic test_directed();
    beat_t       dv [10];
    logic [34:0] de [10];
    logic        v_early, v_on;
    logic [34:0] o;
    dv[0] = mk(0, 23'h000000, 9'd127, 1, 0, 0, 0, 0, 0); de[0] = {32'h3F80_0000, 3'b001};
    dv[1] = mk(0, 23'h000001, 9'd127, 1, 0, 0, 0, 0, 0); de[1] = {32'h3F80_0002, 3'b001};
    dv[2] = mk(0, 23'h7FFFFF, 9'd127, 1, 1, 0, 0, 0, 0); de[2] = {32'h4000_0000, 3'b001};
    dv[3] = mk(1, 23'h7FFFFF, 9'd254, 1, 0, 1, 0, 0, 0); de[3] = {32'hFF80_0000, 3'b101};
    dv[4] = mk(1, 23'h000000, 9'd0,   0, 0, 0, 0, 0, 0); de[4] = {32'h8000_0000, 3'b011};
    dv[5] = mk(1, 23'h123456, 9'd100, 1, 1, 1, 1, 1, 0); de[5] = {32'h7FC0_0000, 3'b000};
    dv[6] = mk(1, 23'h123456, 9'd100, 1, 0, 0, 0, 0, 1); de[6] = {32'h8000_0000, 3'b000};
    dv[7] = mk(0, 23'h000000, 9'd5,   0, 0, 0, 0, 1, 0); de[7] = {32'h7F80_0000, 3'b000};
    dv[8] = mk(0, 23'h000000, 9'd300, 0, 0, 0, 0, 0, 0); de[8] = {32'h7F80_0000, 3'b101};
    dv[9] = mk(0, 23'h7FFFFE, 9'd254, 1, 1, 0, 0, 0, 0); de[9] = {32'h7F7F_FFFF, 3'b001};
    for (int i = 0; i < 10; i++) begin
      run_one(dv[i], v_early, v_on, o);
      n_vec++;
      if (v_early !== 1'b0 || v_on !== 1'b1) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got valid %b%b after 1/2 cycles, expected 01",
                 i, v_early, v_on);
      end
      n_vec++;
      if (o !== de[i]) begin
        n_bad++;
        $display("FAIL directed[%0d]: got %h, expected %h", i, o, de[i]);
      end
    end
  endtask

  task automatic test_random(input int n);
    beat_t       cur = '0;
    logic        have = 1'b0;
    logic [34:0] exq [$];
    logic [34:0] exp_v;
    logic [34:0] held = '0;
    logic        stalled = 1'b0;
    int          sent = 0, got = 0, cyc = 0;
    drain();
    while (got < n && cyc < 30 * n) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < n) begin
        cur  = rand_beat();
        have = 1'b1;
      end
      drive(cur, have && ($urandom_range(0, 3) != 0));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || obs() !== held) begin
          n_bad++;
          $display("FAIL random_hold: got valid %b data %h, expected valid 1 data %h",
                   bus.out_valid, obs(), held);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = obs();
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (exq.size() == 0) begin
          n_bad++;
          $display("FAIL random_spurious: got %h, expected no output", obs());
        end else begin
          exp_v = exq.pop_front();
          if (obs() !== exp_v) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h, expected %h", got, obs(), exp_v);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exq.push_back(model(cur));
        sent++;
        have = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got < n) begin
      n_bad++;
      $display("FAIL random_timeout: got %0d results, expected %0d", got, n);
    end
  endtask

  task automatic test_back_to_back_stall();
    beat_t       b [4];
    logic [34:0] exq [$];
    logic [34:0] held;
    logic [34:0] exp_v;
    int          acc = 0, got = 0, cyc = 0;
    for (int i = 0; i < 4; i++)
      b[i] = mk(i[0], 23'($urandom), 9'(10 + 20 * i), 1'($urandom), 1'($urandom),
                1'($urandom), 0, 0, 0);
    drain();
    for (int c = 0; c < 5; c++) begin
      drive(b[acc < 4 ? acc : 3], acc < 4);
      bus.out_ready = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exq.push_back(model(b[acc]));
        acc++;
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (acc !== 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_fill: got accepted %0d in_ready %b out_valid %b, expected 2 0 1",
               acc, bus.in_ready, bus.out_valid);
    end
    held = obs();
    n_vec++;
    if (held !== exq[0]) begin
      n_bad++;
      $display("FAIL stall_head: got %h, expected %h", held, exq[0]);
    end
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (obs() !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_hold: got %h valid %b, expected %h valid 1", obs(),
               bus.out_valid, held);
    end
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      drive(b[acc < 4 ? acc : 3], acc < 4);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        exp_v = (exq.size() != 0) ? exq.pop_front() : 35'h7_FFFF_FFFF;
        if (obs() !== exp_v) begin
          n_bad++;
          $display("FAIL stall_order[%0d]: got %h, expected %h", got, obs(), exp_v);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exq.push_back(model(b[acc]));
        acc++;
      end
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL stall_count: got %0d results, expected 4", got);
    end
  endtask

  task automatic test_reset_midflight();
    logic        v_early, v_on, seen;
    logic [34:0] o;
    drain();
    bus.out_ready = 1'b0;
    drive(mk(0, 23'h1, 9'd50, 0, 0, 0, 0, 0, 0), 1'b1);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_pre: got out_valid %b in_ready %b, expected 1 0",
               bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_p !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_clear: got out_valid %b out_p %h, expected 0 0",
               bus.out_valid, bus.out_p);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_in_ready: got %b, expected 1", bus.in_ready);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 seen = seen | bus.out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_discard: got stale out_valid %b, expected 0", seen);
    end
    run_one(mk(0, 23'h000000, 9'd128, 0, 0, 0, 0, 0, 0), v_early, v_on, o);
    n_vec++;
    if (v_on !== 1'b1 || o !== {32'h4000_0000, 3'b000}) begin
      n_bad++;
      $display("FAIL midrst_resume: got valid %b data %h, expected 1 %h", v_on, o,
               {32'h4000_0000, 3'b000});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(300);
    test_back_to_back_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fpmult_round_pack
`default_nettype wire
